// File: rtl/fir_pkg.sv
// Shared types for the 6-parallel FIR: sample width, lane count, and the block
// type used by the packer, the FIR core and the output de-packer.
package fir_pkg;

  localparam int DW    = 16;
  localparam int LANES = 6;

  typedef logic signed [DW-1:0] sample_t;
  typedef sample_t blk_t [LANES];

endpackage

// File: rtl/fir_blk_reg.sv
// Output holding register for one 6-lane block with valid/ready semantics.
// Contents stay stable while m_valid is high and m_ready is low.
module fir_blk_reg
  import fir_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  blk_t   blk,
  input  logic   pad,
  input  logic   m_ready,
  output logic   m_valid,
  output blk_t   lanes,
  output logic   m_pad
);

  // Load a new block, retire the current one on handshake, otherwise hold.
  // The caller raises load only when the register is free (!m_valid | m_ready).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pad   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lanes[i] <= '0;
      end
    end else if (load) begin
      m_valid <= 1'b1;
      m_pad   <= pad;
      lanes   <= blk;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= m_valid;
    end
  end

endmodule

// File: rtl/fir_s2p6_packer.sv
// Serial-to-6-lane packer feeding the 6-parallel FIR. One assembly buffer plus
// the output register give double buffering; flush zero-pads a partial block.
module fir_s2p6_packer
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 flush,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] x6k,
  output logic signed [DW-1:0] x6k_1,
  output logic signed [DW-1:0] x6k_2,
  output logic signed [DW-1:0] x6k_3,
  output logic signed [DW-1:0] x6k_4,
  output logic signed [DW-1:0] x6k_5,
  output logic                 m_pad,
  output logic [15:0]          blk_cnt
);

  logic [2:0]  cnt_r;
  blk_t        asm_r;
  logic        asm_full_r;
  logic        asm_pad_r;
  logic [15:0] blk_cnt_r;

  logic        accept_s;
  logic        last_s;
  logic        pad_s;
  logic        complete_s;
  logic        out_free_s;
  logic        load_s;
  logic        load_pad_s;
  logic [3:0]  fill_s;
  blk_t        blk_s;
  blk_t        load_blk_s;
  blk_t        lanes_s;

  // Next assembly contents: incoming sample lands in lane cnt, then flush zeroes
  // every lane at or above the fill level.
  always_comb begin
    accept_s   = s_valid & ~asm_full_r;
    last_s     = accept_s & (cnt_r == 3'd5);
    fill_s     = {1'b0, cnt_r} + {3'b000, accept_s};
    pad_s      = flush & ~asm_full_r & ~last_s & ((cnt_r != 3'd0) | accept_s);
    complete_s = last_s | pad_s;
    out_free_s = ~m_valid | m_ready;
    load_s     = (complete_s | asm_full_r) & out_free_s;
    for (int i = 0; i < LANES; i++) begin
      if (accept_s && (cnt_r == 3'(i))) begin
        blk_s[i] = s_data;
      end else if (pad_s && (4'(i) >= fill_s)) begin
        blk_s[i] = '0;
      end else begin
        blk_s[i] = asm_r[i];
      end
    end
    if (asm_full_r) begin
      load_blk_s = asm_r;
      load_pad_s = asm_pad_r;
    end else begin
      load_blk_s = blk_s;
      load_pad_s = pad_s;
    end
  end

  // Lane counter, assembly buffer and the full flag that backpressures the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 3'd0;
      asm_full_r <= 1'b0;
      asm_pad_r  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        asm_r[i] <= '0;
      end
    end else if (asm_full_r) begin
      if (out_free_s) begin
        asm_full_r <= 1'b0;
      end else begin
        asm_full_r <= 1'b1;
      end
    end else if (complete_s) begin
      cnt_r      <= 3'd0;
      asm_r      <= blk_s;
      asm_pad_r  <= pad_s;
      asm_full_r <= ~out_free_s;
    end else if (accept_s) begin
      asm_r <= blk_s;
      cnt_r <= cnt_r + 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Handed-off block counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_r <= 16'd0;
    end else if (m_valid && m_ready) begin
      blk_cnt_r <= blk_cnt_r + 16'd1;
    end else begin
      blk_cnt_r <= blk_cnt_r;
    end
  end

  fir_blk_reg u_blk_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .blk     (load_blk_s),
    .pad     (load_pad_s),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .lanes   (lanes_s),
    .m_pad   (m_pad)
  );

  assign s_ready = ~asm_full_r;
  assign blk_cnt = blk_cnt_r;
  assign x6k     = lanes_s[0];
  assign x6k_1   = lanes_s[1];
  assign x6k_2   = lanes_s[2];
  assign x6k_3   = lanes_s[3];
  assign x6k_4   = lanes_s[4];
  assign x6k_5   = lanes_s[5];

endmodule

// File: tb/tb_fir_s2p6_packer.sv
// Directed and randomised bench for fir_s2p6_packer; expectations are hand
// computed constants plus a serial-order scoreboard for the random phase.
module tb_fir_s2p6_packer;

  logic               clk;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               flush;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] x6k, x6k_1, x6k_2, x6k_3, x6k_4, x6k_5;
  logic               m_pad;
  logic [15:0]        blk_cnt;

  int n_run  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic [15:0] q[$];

  fir_s2p6_packer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .flush   (flush),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .x6k     (x6k),
    .x6k_1   (x6k_1),
    .x6k_2   (x6k_2),
    .x6k_3   (x6k_3),
    .x6k_4   (x6k_4),
    .x6k_5   (x6k_5),
    .m_pad   (m_pad),
    .blk_cnt (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] lanes_now();
    return {x6k, x6k_1, x6k_2, x6k_3, x6k_4, x6k_5};
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one sample (optionally with flush) and hold it until accepted.
  task automatic push(input logic [15:0] d, input logic fl);
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    flush   = fl;
    guard   = 0;
    while (!s_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!s_ready) chk("push_timeout", s_ready, 96'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard: record accepted samples, compare each handed-off block in order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_valid && s_ready) q.push_back(s_data);
      if (m_valid && m_ready) begin
        if (q.size() >= 6) begin
          chk("rnd_block", lanes_now(), {q[0], q[1], q[2], q[3], q[4], q[5]});
          chk("rnd_pad", m_pad, 96'd0);
          repeat (6) void'(q.pop_front());
        end else begin
          chk("rnd_underflow", q.size(), 96'd6);
        end
      end
    end
  end

  initial begin
    int sent, cyc;
    logic acc, acc_next;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 16'sd0; flush = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mvalid", m_valid, 96'd0);
    chk("rst_sready", s_ready, 96'd1);
    chk("rst_lanes", lanes_now(), 96'd0);
    chk("rst_cnt", blk_cnt, 96'd0);
    rst_n = 1'b1;
    tick();

    // Flush with an empty assembly buffer is ignored.
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("flush_idle", m_valid, 96'd0);

    // 1: six back-to-back samples, zero-bubble output.
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) push(16'(i), 1'b0);
    chk("t1_valid", m_valid, 96'd1);
    chk("t1_lanes", lanes_now(), {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6});
    chk("t1_pad", m_pad, 96'd0);
    tick();
    chk("t1_cnt", blk_cnt, 96'd1);
    chk("t1_drop", m_valid, 96'd0);

    // 2: backpressure, second block waits in the assembly buffer.
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(16'(i), 1'b0);
    chk("t2_hold", lanes_now(), {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6});
    chk("t2_sready0", s_ready, 96'd0);
    tick();
    chk("t2_hold2", lanes_now(), {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6});
    m_ready = 1'b1;
    tick();
    chk("t2_next", lanes_now(), {16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12});
    chk("t2_valid", m_valid, 96'd1);
    chk("t2_sready1", s_ready, 96'd1);
    tick();
    chk("t2_cnt", blk_cnt, 96'd3);

    // 3: two negative samples then a lone flush pulse.
    push(16'hFFFB, 1'b0);
    push(16'hFFFA, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t3_lanes", lanes_now(), {16'hFFFB, 16'hFFFA, 16'd0, 16'd0, 16'd0, 16'd0});
    chk("t3_pad", m_pad, 96'd1);
    chk("t3_valid", m_valid, 96'd1);
    tick();

    // 4: flush together with the 5th sample, then with the 6th sample.
    for (int i = 10; i <= 13; i++) push(16'(i), 1'b0);
    push(16'd14, 1'b1);
    chk("t4_lanes", lanes_now(), {16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd0});
    chk("t4_pad", m_pad, 96'd1);
    tick();
    for (int i = 15; i <= 19; i++) push(16'(i), 1'b0);
    push(16'd20, 1'b1);
    chk("t4_full", lanes_now(), {16'd15, 16'd16, 16'd17, 16'd18, 16'd19, 16'd20});
    chk("t4_nopad", m_pad, 96'd0);
    tick();
    chk("t4_cnt", blk_cnt, 96'd6);

    // 5: reset mid-block discards the partial block.
    m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push(16'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_lanes", lanes_now(), 96'd0);
    chk("t5_rst_valid", m_valid, 96'd0);
    chk("t5_rst_cnt", blk_cnt, 96'd0);
    chk("t5_rst_sready", s_ready, 96'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 7; i <= 12; i++) push(16'(i), 1'b0);
    chk("t5_lanes", lanes_now(), {16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12});
    chk("t5_pad", m_pad, 96'd0);
    m_ready = 1'b1;
    tick();
    chk("t5_cnt", blk_cnt, 96'd1);

    // 6: random valid/ready traffic, 200 full blocks checked by the scoreboard.
    mon_en = 1'b1;
    sent = 0; cyc = 0; acc = 1'b0;
    while (sent < 1200 && cyc < 20000) begin
      if (!s_valid || acc) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 16'($urandom);
      end
      m_ready  = 1'($urandom_range(0, 1));
      acc_next = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc_next) sent++;
      acc = acc_next;
      cyc++;
      if (sent == 1200) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (20) tick();
    mon_en = 1'b0;
    chk("t6_sent", sent, 96'd1200);
    chk("t6_drain", q.size(), 96'd0);
    chk("t6_cnt", blk_cnt, 96'd201);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
